sa_read_channel: RTL

- Slave-arbitration read channel: the slave-side counterpart of the per-master read dispatcher.
- Collects AR requests from MST_AMT dispatchers and round-robin arbitrates them onto one slave AR port.
- Records grant order in an outstanding FIFO and steers the slave's R beats back to the owning dispatcher, in order, popping on RLAST.
- One instance per slave inside the interconnect.

---
 rtl/sa_read_channel_if.sv | 61 ++++++
 rtl/sa_read_channel.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sa_read_channel_if.sv
// Bundle of the dispatcher-facing and slave-facing AR/R signals of one slave read channel.
interface sa_read_channel_if #(
    parameter int unsigned MST_AMT           = 2,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned TRANS_MST_ID_W    = 5,
    parameter int unsigned TRANS_BURST_W     = 2,
    parameter int unsigned TRANS_DATA_LEN_W  = 3,
    parameter int unsigned TRANS_DATA_SIZE_W = 3,
    parameter int unsigned TRANS_WR_RESP_W   = 2
);
    // Dispatcher side, master m at slice m
    logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_ARID_i;
    logic [ADDR_WIDTH*MST_AMT-1:0]        dsp_ARADDR_i;
    logic [TRANS_BURST_W*MST_AMT-1:0]     dsp_ARBURST_i;
    logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  dsp_ARLEN_i;
    logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] dsp_ARSIZE_i;
    logic [MST_AMT-1:0]                   dsp_ARVALID_i;
    logic [MST_AMT-1:0]                   dsp_ARREADY_o;
    logic [TRANS_MST_ID_W-1:0]            dsp_RID_o;
    logic [DATA_WIDTH-1:0]                dsp_RDATA_o;
    logic [TRANS_WR_RESP_W-1:0]           dsp_RRESP_o;
    logic                                 dsp_RLAST_o;
    logic [MST_AMT-1:0]                   dsp_RVALID_o;
    logic [MST_AMT-1:0]                   dsp_RREADY_i;

    // Slave side
    logic [TRANS_MST_ID_W-1:0]            s_ARID_o;
    logic [ADDR_WIDTH-1:0]                s_ARADDR_o;
    logic [TRANS_BURST_W-1:0]             s_ARBURST_o;
    logic [TRANS_DATA_LEN_W-1:0]          s_ARLEN_o;
    logic [TRANS_DATA_SIZE_W-1:0]         s_ARSIZE_o;
    logic                                 s_ARVALID_o;
    logic                                 s_ARREADY_i;
    logic [TRANS_MST_ID_W-1:0]            s_RID_i;
    logic [DATA_WIDTH-1:0]                s_RDATA_i;
    logic [TRANS_WR_RESP_W-1:0]           s_RRESP_i;
    logic                                 s_RLAST_i;
    logic                                 s_RVALID_i;
    logic                                 s_RREADY_o;

    // View of the read channel block itself
    modport slave (
        input  dsp_ARID_i, dsp_ARADDR_i, dsp_ARBURST_i, dsp_ARLEN_i, dsp_ARSIZE_i,
        input  dsp_ARVALID_i, dsp_RREADY_i,
        input  s_ARREADY_i, s_RID_i, s_RDATA_i, s_RRESP_i, s_RLAST_i, s_RVALID_i,
        output dsp_ARREADY_o, dsp_RID_o, dsp_RDATA_o, dsp_RRESP_o, dsp_RLAST_o, dsp_RVALID_o,
        output s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o, s_ARVALID_o,
        output s_RREADY_o
    );

    // View of the surrounding dispatchers and slave
    modport master (
        output dsp_ARID_i, dsp_ARADDR_i, dsp_ARBURST_i, dsp_ARLEN_i, dsp_ARSIZE_i,
        output dsp_ARVALID_i, dsp_RREADY_i,
        output s_ARREADY_i, s_RID_i, s_RDATA_i, s_RRESP_i, s_RLAST_i, s_RVALID_i,
        input  dsp_ARREADY_o, dsp_RID_o, dsp_RDATA_o, dsp_RRESP_o, dsp_RLAST_o, dsp_RVALID_o,
        input  s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o, s_ARVALID_o,
        input  s_RREADY_o
    );
endinterface

// File: rtl/sa_read_channel.sv
// Slave-side read channel: round-robin AR arbitration across dispatchers,
// grant-order FIFO, and in-order R steering back to the owning dispatcher.
module sa_read_channel #(
    parameter int unsigned MST_AMT           = 2,
    parameter int unsigned OUTSTANDING_AMT   = 8,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned TRANS_MST_ID_W    = 5,
    parameter int unsigned TRANS_BURST_W     = 2,
    parameter int unsigned TRANS_DATA_LEN_W  = 3,
    parameter int unsigned TRANS_DATA_SIZE_W = 3,
    parameter int unsigned TRANS_WR_RESP_W   = 2
) (
    input logic              ACLK_i,
    input logic              ARESET_i,
    sa_read_channel_if.slave bus
);
    localparam int unsigned MST_ID_W = (MST_AMT > 1) ? $clog2(MST_AMT) : 1;
    localparam int unsigned PTR_W    = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
    localparam int unsigned CNT_W    = $clog2(OUTSTANDING_AMT) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                       state_q;
    logic                         arvalid_q;
    logic [TRANS_MST_ID_W-1:0]    arid_q;
    logic [ADDR_WIDTH-1:0]        araddr_q;
    logic [TRANS_BURST_W-1:0]     arburst_q;
    logic [TRANS_DATA_LEN_W-1:0]  arlen_q;
    logic [TRANS_DATA_SIZE_W-1:0] arsize_q;
    logic [MST_ID_W-1:0]          rr_ptr_q;
    logic [MST_ID_W-1:0]          fifo_q [OUTSTANDING_AMT];
    logic [PTR_W-1:0]             wr_ptr_q;
    logic [PTR_W-1:0]             rd_ptr_q;
    logic [CNT_W-1:0]             count_q;

    logic [MST_AMT-1:0]           eligible_c;
    logic [2*MST_AMT-1:0]         rotated_c;
    logic                         grant_vld_c;
    logic [MST_ID_W-1:0]          grant_c;
    logic [MST_ID_W-1:0]          rr_next_c;
    logic [TRANS_MST_ID_W-1:0]    sel_id_c;
    logic [ADDR_WIDTH-1:0]        sel_addr_c;
    logic [TRANS_BURST_W-1:0]     sel_burst_c;
    logic [TRANS_DATA_LEN_W-1:0]  sel_len_c;
    logic [TRANS_DATA_SIZE_W-1:0] sel_size_c;
    logic [MST_AMT-1:0]           ar_ready_c;
    logic [MST_ID_W-1:0]          head_c;
    logic                         empty_c;
    logic [MST_AMT-1:0]           r_valid_c;
    logic                         s_rready_c;
    logic                         push_c;
    logic                         pop_c;

    // Round-robin pick: first eligible master at or after the pointer; full FIFO blocks all
    always_comb begin
        eligible_c = bus.dsp_ARVALID_i;
        if (count_q == CNT_W'(OUTSTANDING_AMT)) begin
            eligible_c = '0;
        end
        rotated_c   = {eligible_c, eligible_c} >> rr_ptr_q;
        grant_vld_c = 1'b0;
        grant_c     = '0;
        rr_next_c   = rr_ptr_q;
        for (int i = 0; i < int'(MST_AMT); i++) begin
            if (!grant_vld_c && rotated_c[i]) begin
                grant_vld_c = 1'b1;
                grant_c     = MST_ID_W'((int'(rr_ptr_q) + i) % int'(MST_AMT));
                rr_next_c   = MST_ID_W'((int'(rr_ptr_q) + i + 1) % int'(MST_AMT));
            end
        end
    end

    // Mux the granted master's AR payload and form its one-hot ready
    always_comb begin
        sel_id_c    = '0;
        sel_addr_c  = '0;
        sel_burst_c = '0;
        sel_len_c   = '0;
        sel_size_c  = '0;
        ar_ready_c  = '0;
        for (int j = 0; j < int'(MST_AMT); j++) begin
            if (grant_c == MST_ID_W'(j)) begin
                sel_id_c    = bus.dsp_ARID_i[j*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                sel_addr_c  = bus.dsp_ARADDR_i[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_burst_c = bus.dsp_ARBURST_i[j*TRANS_BURST_W +: TRANS_BURST_W];
                sel_len_c   = bus.dsp_ARLEN_i[j*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
                sel_size_c  = bus.dsp_ARSIZE_i[j*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
                if (state_q == ST_IDLE && grant_vld_c && !ARESET_i) begin
                    ar_ready_c[j] = 1'b1;
                end
            end
        end
    end

    // Steer R handshake to the master at the head of the grant-order FIFO
    always_comb begin
        head_c     = fifo_q[rd_ptr_q];
        empty_c    = (count_q == '0);
        r_valid_c  = '0;
        s_rready_c = 1'b0;
        for (int j = 0; j < int'(MST_AMT); j++) begin
            if (!empty_c && !ARESET_i && head_c == MST_ID_W'(j)) begin
                r_valid_c[j] = bus.s_RVALID_i;
                s_rready_c   = bus.dsp_RREADY_i[j];
            end
        end
        push_c = (state_q == ST_IDLE) && grant_vld_c;
        pop_c  = bus.s_RVALID_i && s_rready_c && bus.s_RLAST_i;
    end

    // AR FSM, payload capture, RR pointer and grant-order FIFO bookkeeping
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            state_q   <= ST_IDLE;
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arburst_q <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int k = 0; k < int'(OUTSTANDING_AMT); k++) begin
                fifo_q[k] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_c) begin
                        arid_q    <= sel_id_c;
                        araddr_q  <= sel_addr_c;
                        arburst_q <= sel_burst_c;
                        arlen_q   <= sel_len_c;
                        arsize_q  <= sel_size_c;
                        rr_ptr_q  <= rr_next_c;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.s_ARREADY_i) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
            if (push_c) begin
                fifo_q[wr_ptr_q] <= grant_c;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign bus.dsp_ARREADY_o = ar_ready_c;
    assign bus.s_ARVALID_o   = arvalid_q;
    assign bus.s_ARID_o      = arid_q;
    assign bus.s_ARADDR_o    = araddr_q;
    assign bus.s_ARBURST_o   = arburst_q;
    assign bus.s_ARLEN_o     = arlen_q;
    assign bus.s_ARSIZE_o    = arsize_q;
    assign bus.dsp_RVALID_o  = r_valid_c;
    assign bus.s_RREADY_o    = s_rready_c;
    assign bus.dsp_RID_o     = bus.s_RID_i;
    assign bus.dsp_RDATA_o   = bus.s_RDATA_i;
    assign bus.dsp_RRESP_o   = bus.s_RRESP_i;
    assign bus.dsp_RLAST_o   = bus.s_RLAST_i;
endmodule
